// File: rtl/vpe_fetch_scheduler_if.sv
// Bundle of feature-mux, lane and result signals around the VPE fetch scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface vpe_fetch_scheduler_if;
  logic         i_feat_pending;
  logic         o_fetch;
  logic [255:0] i_feature;
  logic [7:0]   i_mux_valid;
  logic [3:0]   o_lane_load;
  logic [255:0] o_lane_feature;
  logic [7:0]   o_lane_mux;
  logic [3:0]   i_lane_done;
  logic [15:0]  i_lane_res;
  logic [3:0]   o_inf_res;
  logic         o_inf_res_valid;
  logic [3:0]   o_lane_busy;
  logic [7:0]   o_timeout_cnt;

  modport master (
    input  i_feat_pending, i_feature, i_mux_valid, i_lane_done, i_lane_res,
    output o_fetch, o_lane_load, o_lane_feature, o_lane_mux,
           o_inf_res, o_inf_res_valid, o_lane_busy, o_timeout_cnt
  );

  modport slave (
    output i_feat_pending, i_feature, i_mux_valid, i_lane_done, i_lane_res,
    input  o_fetch, o_lane_load, o_lane_feature, o_lane_mux,
           o_inf_res, o_inf_res_valid, o_lane_busy, o_timeout_cnt
  );
endinterface

// File: rtl/vpe_fetch_scheduler.sv
// VPE fetch scheduler: fetches features from the feature mux, dispatches them
// round-robin to four lanes, and retires lane results in dispatch order.
module vpe_fetch_scheduler #(
  parameter int N_LANES = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_octo,
  input  logic                   rst_octo,
  vpe_fetch_scheduler_if.master  bus
);

  localparam int             CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_V = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [1:0]               dp_q, dp_d;
  logic [1:0]               rp_q, rp_d;
  logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [7:0]               timeout_cnt_q, timeout_cnt_d;
  logic [255:0]             lane_feature_q, lane_feature_d;
  logic [7:0]               lane_mux_q, lane_mux_d;
  logic [N_LANES-1:0]       busy_q, busy_d;
  logic [N_LANES-1:0]       done_q, done_d;
  logic [N_LANES-1:0][3:0]  res_q, res_d;
  logic [3:0]               inf_res_q, inf_res_d;
  logic                     inf_res_valid_q, inf_res_valid_d;
  logic [N_LANES-1:0]       busy_set;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Fetch FSM: request, wait for mux data with timeout, then load the lane at dp.
  always_comb begin
    state_d        = state_q;
    dp_d           = dp_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    lane_feature_d = lane_feature_q;
    lane_mux_d     = lane_mux_q;
    busy_set       = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_feat_pending && !busy_q[dp_q]) state_d = S_REQ;
      end
      S_REQ: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_mux_valid != 8'd0) begin
          lane_feature_d = bus.i_feature;
          lane_mux_d     = bus.i_mux_valid;
          state_d        = S_LOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d == TMO_V) begin
            timeout_cnt_d = sat_inc8(timeout_cnt_q);
            state_d       = S_IDLE;
          end
        end
      end
      default: begin
        busy_set[dp_q] = 1'b1;
        dp_d           = dp_q + 2'd1;
        state_d        = S_IDLE;
      end
    endcase
  end

  // Lane bookkeeping: latch done strobes of busy lanes, retire strictly at rp.
  always_comb begin
    busy_d          = busy_q | busy_set;
    done_d          = done_q;
    res_d           = res_q;
    rp_d            = rp_q;
    inf_res_d       = inf_res_q;
    inf_res_valid_d = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (bus.i_lane_done[k] && busy_q[k]) begin
        res_d[k]  = bus.i_lane_res[4*k +: 4];
        done_d[k] = 1'b1;
      end
    end
    // Retire is evaluated last so its clear of busy/done always takes effect.
    if (done_q[rp_q]) begin
      inf_res_d       = res_q[rp_q];
      inf_res_valid_d = 1'b1;
      busy_d[rp_q]    = 1'b0;
      done_d[rp_q]    = 1'b0;
      rp_d            = rp_q + 2'd1;
    end
  end

  // State registers; reset also discards any in-flight feature.
  always_ff @(posedge clk_octo or posedge rst_octo) begin
    if (rst_octo) begin
      state_q         <= S_IDLE;
      dp_q            <= '0;
      rp_q            <= '0;
      wait_cnt_q      <= '0;
      timeout_cnt_q   <= '0;
      lane_feature_q  <= '0;
      lane_mux_q      <= '0;
      busy_q          <= '0;
      done_q          <= '0;
      res_q           <= '0;
      inf_res_q       <= '0;
      inf_res_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      dp_q            <= dp_d;
      rp_q            <= rp_d;
      wait_cnt_q      <= wait_cnt_d;
      timeout_cnt_q   <= timeout_cnt_d;
      lane_feature_q  <= lane_feature_d;
      lane_mux_q      <= lane_mux_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      res_q           <= res_d;
      inf_res_q       <= inf_res_d;
      inf_res_valid_q <= inf_res_valid_d;
    end
  end

  assign bus.o_fetch         = (state_q == S_REQ);
  assign bus.o_lane_load     = (state_q == S_LOAD) ? (4'b0001 << dp_q) : 4'b0000;
  assign bus.o_lane_feature  = lane_feature_q;
  assign bus.o_lane_mux      = lane_mux_q;
  assign bus.o_inf_res       = inf_res_q;
  assign bus.o_inf_res_valid = inf_res_valid_q;
  assign bus.o_lane_busy     = busy_q;
  assign bus.o_timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_vpe_fetch_scheduler.sv
// Self-checking bench for vpe_fetch_scheduler: directed scenarios plus
// randomized rounds against a job-queue reference model.
module tb_vpe_fetch_scheduler;
  localparam int TMO = 15;

  logic clk_octo = 1'b0;
  logic rst_octo = 1'b1;
  always #5 clk_octo = ~clk_octo;

  vpe_fetch_scheduler_if bus();

  vpe_fetch_scheduler #(.N_LANES(4), .TIMEOUT(TMO)) dut (
    .clk_octo (clk_octo),
    .rst_octo (rst_octo),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fetch_cnt = 0;
  int load_cnt  = 0;

  // Reference model: dispatch pointer, lanes holding jobs, timeout count,
  // lanes in dispatch order and their results; retires follow dispatch order.
  int         dp_m;
  int         tmo_m;
  logic [3:0] busy_m;
  logic [3:0] res_m [4];
  int         jobs_q[$];
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_octo);
    #1;
    if (bus.o_inf_res_valid === 1'b1) got_q.push_back(bus.o_inf_res);
    if (bus.o_lane_load !== 4'b0000) load_cnt++;
    if (bus.o_fetch === 1'b1) fetch_cnt++;
  endtask

  task automatic do_reset();
    rst_octo           = 1'b1;
    bus.i_feat_pending = 1'b0;
    bus.i_feature      = '0;
    bus.i_mux_valid    = '0;
    bus.i_lane_done    = '0;
    bus.i_lane_res     = '0;
    repeat (2) tick();
    check("rst_fetch",   bus.o_fetch, 0);
    check("rst_load",    bus.o_lane_load, 0);
    check("rst_feature", bus.o_lane_feature, 0);
    check("rst_mux",     bus.o_lane_mux, 0);
    check("rst_res",     bus.o_inf_res, 0);
    check("rst_resv",    bus.o_inf_res_valid, 0);
    check("rst_busy",    bus.o_lane_busy, 0);
    check("rst_tmo",     bus.o_timeout_cnt, 0);
    rst_octo = 1'b0;
    dp_m = 0; tmo_m = 0; busy_m = '0;
    jobs_q.delete(); got_q.delete(); exp_q.delete();
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    bus.i_feat_pending = 1'b1;
    while (bus.o_fetch !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("fetch_seen", bus.o_fetch, 1);
    bus.i_feat_pending = 1'b0;
  endtask

  // dly < 0 means the mux never answers and the fetch times out.
  task automatic dispatch(input logic [255:0] f, input logic [7:0] mv, input int dly);
    int l0;
    wait_fetch();
    l0 = load_cnt;
    tick();
    if (dly < 0) begin
      repeat (TMO - 1) tick();
      check("tmo_before", bus.o_timeout_cnt, tmo_m);
      tick();
      if (tmo_m < 255) tmo_m++;
      check("tmo_after", bus.o_timeout_cnt, tmo_m);
      check("tmo_noload", load_cnt - l0, 0);
    end else begin
      repeat (dly) tick();
      bus.i_feature   = f;
      bus.i_mux_valid = mv;
      tick();
      bus.i_mux_valid = '0;
      check("load_lane", bus.o_lane_load, 4'b0001 << dp_m);
      check("load_feat", bus.o_lane_feature, f);
      check("load_mux",  bus.o_lane_mux, mv);
      busy_m[dp_m] = 1'b1;
      jobs_q.push_back(dp_m);
      dp_m = (dp_m + 1) % 4;
      tick();
      check("busy_after_load", bus.o_lane_busy, busy_m);
    end
  endtask

  task automatic set_done(input logic [3:0] m, input logic [15:0] r);
    bus.i_lane_done = m;
    bus.i_lane_res  = r;
    tick();
    bus.i_lane_done = '0;
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int f0, l0, guard;

    // Reset values, and no fetch in the first cycle after release.
    do_reset();
    bus.i_feat_pending = 1'b1;
    check("fetch_after_rst", bus.o_fetch, 0);
    bus.i_feat_pending = 1'b0;

    // Single job through lane 0.
    dispatch({32{8'hA5}}, 8'h01, 0);
    set_done(4'b0001, 16'h0003);
    repeat (4) tick();
    exp_q.push_back(4'h3);
    check_got("single_res");
    check("single_busy", bus.o_lane_busy, 0);
    check("res_hold", bus.o_inf_res, 4'h3);
    check("res_hold_v", bus.o_inf_res_valid, 0);
    jobs_q.delete(); busy_m = '0;

    // Mux valid outside WAIT must not load anything.
    l0 = load_cnt;
    bus.i_mux_valid = 8'hFF;
    repeat (5) tick();
    bus.i_mux_valid = '0;
    check("mux_ignored", load_cnt - l0, 0);

    // Round robin over four lanes, blocked fetch, reordered completion.
    do_reset();
    for (int j = 0; j < 4; j++) dispatch({8{32'($urandom)}}, 8'(j + 1), 0);
    check("all_busy", bus.o_lane_busy, 4'b1111);
    f0 = fetch_cnt;
    bus.i_feat_pending = 1'b1;
    repeat (8) tick();
    bus.i_feat_pending = 1'b0;
    check("blocked_fetch", fetch_cnt - f0, 0);
    set_done(4'b1000, 16'hD000);
    repeat (4) tick();
    check("hold_ooo_3", got_q.size(), 0);
    set_done(4'b0010, 16'h00B0);
    repeat (4) tick();
    check("hold_ooo_1", got_q.size(), 0);
    set_done(4'b0001, 16'h000A);
    repeat (6) tick();
    check("busy_after_ab", bus.o_lane_busy, 4'b1100);
    busy_m = 4'b1100;
    dispatch({32{8'h5A}}, 8'h80, 1);
    set_done(4'b0100, 16'h0C00);
    set_done(4'b0001, 16'h000E);
    repeat (10) tick();
    exp_q = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    check_got("reorder");
    check("reorder_busy", bus.o_lane_busy, 0);
    jobs_q.delete(); busy_m = '0;

    // Timeout leaves dp unchanged.
    do_reset();
    dispatch('0, '0, -1);
    dispatch({16{16'h1234}}, 8'h10, 2);
    set_done(4'b0001, 16'h0007);
    repeat (4) tick();
    exp_q.push_back(4'h7);
    check_got("after_tmo");
    jobs_q.delete(); busy_m = '0;

    // Randomized rounds: random loads/timeouts, then random completion order.
    for (int rnd = 0; rnd < 4; rnd++) begin
      int target, loads, g;
      logic [3:0] pend;
      target = $urandom_range(1, 4);
      loads = 0;
      while (loads < target) begin
        if ($urandom_range(0, 4) == 0) dispatch('0, '0, -1);
        else begin
          dispatch({8{32'($urandom)}}, 8'($urandom_range(1, 255)), $urandom_range(0, 14));
          loads++;
        end
      end
      pend = busy_m;
      g = 0;
      while (pend != 4'b0000 && g < 200) begin
        logic [3:0]  mask;
        logic [15:0] r;
        g++;
        mask = 4'($urandom) & (pend | ~busy_m);
        if ((mask & pend) == 4'b0000) continue;
        r = 16'($urandom);
        for (int k = 0; k < 4; k++) if (mask[k] && pend[k]) res_m[k] = r[4*k +: 4];
        pend = pend & ~mask;
        set_done(mask, r);
        repeat ($urandom_range(0, 3)) tick();
      end
      repeat (12) tick();
      foreach (jobs_q[i]) exp_q.push_back(res_m[jobs_q[i]]);
      check_got("rand_retire");
      check("rand_busy", bus.o_lane_busy, 0);
      jobs_q.delete(); busy_m = '0;
    end

    // Timeout counter saturation over 260 consecutive timeouts.
    do_reset();
    f0 = fetch_cnt;
    l0 = load_cnt;
    guard = 0;
    bus.i_feat_pending = 1'b1;
    while (fetch_cnt - f0 < 260 && guard < 260 * 17 + 200) begin
      tick();
      guard++;
    end
    bus.i_feat_pending = 1'b0;
    repeat (20) tick();
    check("sat_fetches", fetch_cnt - f0, 260);
    check("sat_cnt", bus.o_timeout_cnt, 255);
    check("sat_noload", load_cnt - l0, 0);
    tmo_m = 255;

    // Reset while data arrives in WAIT: feature discarded, no load strobe.
    dispatch({32{8'h3C}}, 8'h04, 0);
    wait_fetch();
    tick();
    bus.i_feature   = {256{1'b1}};
    bus.i_mux_valid = 8'hFF;
    #2;
    rst_octo = 1'b1;
    #1;
    check("rw_load",    bus.o_lane_load, 0);
    check("rw_feature", bus.o_lane_feature, 0);
    check("rw_mux",     bus.o_lane_mux, 0);
    check("rw_busy",    bus.o_lane_busy, 0);
    check("rw_tmo",     bus.o_timeout_cnt, 0);
    check("rw_resv",    bus.o_inf_res_valid, 0);
    l0 = load_cnt;
    tick();
    rst_octo        = 1'b0;
    bus.i_mux_valid = '0;
    repeat (6) tick();
    check("rw_noload", load_cnt - l0, 0);
    check("rw_feat_after", bus.o_lane_feature, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
